// File: rtl/pipe_pkg.sv
// pipe_pkg: field widths, bit offsets and packed instruction word shared by the issue unit and the pipeline.
package pipe_pkg;
  localparam int REG_W = 4;
  localparam int FUNC_W = 4;
  localparam int ADDR_W = 8;
  localparam int INSTR_W = 24;
  localparam int FUNC_LSB = 20;
  localparam int RS1_LSB = 16;
  localparam int RS2_LSB = 12;
  localparam int RD_LSB = 8;
  localparam int ADDR_LSB = 0;
  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [ADDR_W-1:0] addr;
  } instr_t;
  function automatic instr_t unpack_instr(input logic [INSTR_W-1:0] w);
    instr_t r;
    r.func = w[FUNC_LSB +: FUNC_W];
    r.rs1 = w[RS1_LSB +: REG_W];
    r.rs2 = w[RS2_LSB +: REG_W];
    r.rd = w[RD_LSB +: REG_W];
    r.addr = w[ADDR_LSB +: ADDR_W];
    return r;
  endfunction
endpackage

// File: rtl/issue_fifo.sv
// issue_fifo: power-of-two circular FIFO with occupancy count and full/empty flags.
module issue_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 24
) (
  input  logic         clk1,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  assign dout = mem[rp];
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  always_ff @(posedge clk1) begin
    if (push) mem[wp] <= din;
  end
endmodule

// File: rtl/pipe_issue.sv
// pipe_issue: buffered in-order issue unit with RAW scoreboard and issue/stall counters.
// Scoreboard and stall logic are present only when PIPE_ISSUE_HAZARD_EN is defined.
module pipe_issue
  import pipe_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int HAZ_WIN = 2
) (
  input  logic               clk1,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  output logic [REG_W-1:0]   rs1,
  output logic [REG_W-1:0]   rs2,
  output logic [REG_W-1:0]   rd,
  output logic [FUNC_W-1:0]  func,
  output logic [ADDR_W-1:0]  addr,
  output logic [15:0]        issue_cnt,
  output logic [15:0]        stall_cnt
);
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || HAZ_WIN < 1 || HAZ_WIN > 4) begin : g_bad
    $error("pipe_issue: DEPTH or HAZ_WIN out of range");
  end
  logic full, empty, hazard, pop;
  logic [INSTR_W-1:0] head_w;
  instr_t head;
  assign head = unpack_instr(head_w);
  assign in_ready = !full;
  assign pop = !empty && !hazard;
  issue_fifo #(.DEPTH(DEPTH), .W(INSTR_W)) u_fifo (
    .clk1(clk1), .rst_n(rst_n), .push(in_valid && in_ready), .pop(pop),
    .din(in_instr), .dout(head_w), .full(full), .empty(empty)
  );
`ifdef PIPE_ISSUE_HAZARD_EN
  logic [HAZ_WIN-1:0] sb_v;
  logic [REG_W-1:0] sb_rd [HAZ_WIN];
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_WIN; i++)
      hazard |= sb_v[i] && (sb_rd[i] == head.rs1 || sb_rd[i] == head.rs2);
  end
  // Each slot ages one cycle per edge; a bubble shifts in an invalid slot.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      sb_v <= '0;
      for (int i = 0; i < HAZ_WIN; i++) sb_rd[i] <= '0;
      stall_cnt <= '0;
    end else begin
      sb_v[0] <= pop;
      sb_rd[0] <= head.rd;
      for (int i = 1; i < HAZ_WIN; i++) begin
        sb_v[i] <= sb_v[i-1];
        sb_rd[i] <= sb_rd[i-1];
      end
      if (!empty && hazard && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign hazard = 1'b0;
  assign stall_cnt = '0;
`endif
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      func <= '0;
      rs1 <= '0;
      rs2 <= '0;
      rd <= '0;
      addr <= '0;
      issue_cnt <= '0;
    end else begin
      out_valid <= pop;
      if (pop) begin
        func <= head.func;
        rs1 <= head.rs1;
        rs2 <= head.rs2;
        rd <= head.rd;
        addr <= head.addr;
      end
      if (pop && issue_cnt != 16'hFFFF) issue_cnt <= issue_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_pipe_issue.sv
// tb_pipe_issue: randomized and directed stimulus against a queue-based issue model; honours PIPE_ISSUE_HAZARD_EN.
module tb_pipe_issue;
  localparam int DEPTH = 4;
  localparam int HAZ_WIN = 2;
  logic clk1 = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid;
  logic [23:0] in_instr;
  logic [3:0] rs1, rs2, rd, func;
  logic [7:0] addr;
  logic [15:0] issue_cnt, stall_cnt;
  int n_tests = 0;
  int n_fail = 0;
  logic [23:0] q[$];
  int last[16];
  int cyc = 0;
  logic e_valid;
  logic [23:0] e_word;
  int e_ic, e_sc;
  bit acc;

  pipe_issue #(.DEPTH(DEPTH), .HAZ_WIN(HAZ_WIN)) dut (
    .clk1(clk1), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr),
    .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk1 = ~clk1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] mk(int f, int a, int b, int d, int ad);
    return {f[3:0], a[3:0], b[3:0], d[3:0], ad[7:0]};
  endfunction

  // A source register is blocked while its last writer issued within the past HAZ_WIN edges.
  function automatic bit haz(logic [23:0] w);
`ifdef PIPE_ISSUE_HAZARD_EN
    return (cyc - last[w[19:16]] <= HAZ_WIN) || (cyc - last[w[15:12]] <= HAZ_WIN);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    foreach (last[i]) last[i] = -100;
    e_valid = 1'b0;
    e_word = '0;
    e_ic = 0;
    e_sc = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, out_valid, e_valid);
    check({tag, ".fields"}, {func, rs1, rs2, rd, addr}, e_word);
    check({tag, ".issue_cnt"}, issue_cnt, e_ic);
    check({tag, ".stall_cnt"}, stall_cnt, e_sc);
  endtask

  task automatic step(input string tag, input logic v, input logic [23:0] w, output bit accepted);
    logic [23:0] h;
    in_valid = v;
    in_instr = w;
    check({tag, ".in_ready"}, in_ready, q.size() < DEPTH);
    accepted = v && q.size() < DEPTH;
    cyc++;
    if (q.size() > 0 && !haz(q[0])) begin
      h = q.pop_front();
      e_valid = 1'b1;
      e_word = h;
      last[h[11:8]] = cyc;
      if (e_ic < 65535) e_ic++;
    end else begin
      e_valid = 1'b0;
      if (q.size() > 0 && e_sc < 65535) e_sc++;
    end
    if (accepted) q.push_back(w);
    @(posedge clk1);
    #1;
    check_outputs(tag);
  endtask

  task automatic push_all(input string tag, input logic [23:0] w);
    bit a;
    int n;
    a = 0;
    n = 0;
    while (!a && n < 20) begin
      step(tag, 1'b1, w, a);
      n++;
    end
    check({tag, ".accept"}, a, 1'b1);
  endtask

  task automatic idle(input string tag, input int n);
    bit a;
    for (int i = 0; i < n; i++) step(tag, 1'b0, '0, a);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    model_reset();
    repeat (2) @(posedge clk1);
    #1;
    check_outputs("reset");
    check("reset.in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    push_all("indep", mk(0, 3, 5, 10, 125));
    push_all("indep", mk(2, 3, 8, 12, 126));
    push_all("indep", mk(11, 7, 3, 14, 127));
    idle("indep", 4);

    push_all("raw1", mk(0, 3, 5, 10, 125));
    push_all("raw1", mk(1, 10, 5, 13, 128));
    idle("raw1", 5);
    push_all("raw2", mk(0, 3, 5, 10, 125));
    push_all("raw2", mk(1, 4, 10, 13, 128));
    idle("raw2", 5);
    push_all("self", mk(3, 7, 1, 7, 9));
    push_all("self", mk(4, 2, 6, 6, 10));
    idle("self", 4);

    for (int i = 0; i < 9; i++) push_all("full", mk(i, i, i, i + 1, i));
    idle("full", 30);

    for (int i = 0; i < 400; i++)
      step("rand", $urandom_range(0, 9) < 7,
           mk($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 255)), acc);
    idle("rand", 30);

    force dut.issue_cnt = 16'hFFFE;
    #1;
    release dut.issue_cnt;
    e_ic = 16'hFFFE;
    push_all("sat", mk(1, 1, 1, 2, 1));
    push_all("sat", mk(2, 3, 3, 4, 2));
    push_all("sat", mk(3, 5, 5, 6, 3));
    idle("sat", 12);
    check("sat.hold", issue_cnt, 16'hFFFF);

    push_all("rstmid", mk(0, 1, 2, 3, 0));
    push_all("rstmid", mk(0, 3, 3, 4, 1));
    push_all("rstmid", mk(0, 4, 4, 5, 2));
    rst_n = 1'b0;
    #2;
    model_reset();
    check_outputs("rstmid");
    check("rstmid.in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    idle("rstmid.after", 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
